cpu_run_controller: RTL and testbench



---
 rtl/cpu_dbg_pkg.sv | 26 ++
 rtl/cpu_run_controller_debounce.sv | 51 +++++
 rtl/cpu_run_controller.sv | 147 ++++++++++++++
 tb/tb_cpu_run_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the teaching-CPU run/step controller: the mode
// selector codes from the DE2 switches and the controller state encoding.
package cpu_dbg_pkg;

    localparam logic [1:0] MODE_STEP = 2'b00;
    localparam logic [1:0] MODE_FREE = 2'b01;
    localparam logic [1:0] MODE_RUNN = 2'b10;
    localparam logic [1:0] MODE_BRK  = 2'b11;

    localparam int STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE = 3'd0,
        ST_STEP = 3'd1,
        ST_RUN  = 3'd2,
        ST_RUNN = 3'd3,
        ST_BRK  = 3'd4,
        ST_HALT = 3'd5
    } run_state_t;

    // States that issue enables at the divided run rate
    function automatic logic is_divided(input run_state_t s);
        return (s == ST_RUN) || (s == ST_RUNN) || (s == ST_BRK);
    endfunction

endpackage

// File: rtl/cpu_run_controller_debounce.sv
// Pushbutton conditioning: two-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted press. A held button yields one pulse.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic [CNT_W-1:0] stable_cnt;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= button_raw;
            sync_2 <= sync_1;
        end
    end

    // Accept a new level only after enough consecutive identical samples; pulse on rise
    always_ff @(posedge clock) begin
        if (reset) begin
            level      <= 1'b0;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync_2;
                stable_cnt <= '0;
                press      <= sync_2;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Run/step controller for the teaching CPU. Everything runs on the 50 MHz
// clock; the CPU advances only on the one-cycle cpu_enable strobe, issued
// per button press (STEP) or at a divided rate (FREE, RUN_N, BREAK).
module cpu_run_controller
    import cpu_dbg_pkg::*;
#(
    parameter int RUN_DIV         = 500000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int COUNT_WIDTH     = 16,
    parameter int PC_WIDTH        = 32,
    parameter int RUNN_WIDTH      = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic                   button_raw,
    input  logic                   count_clear,
    input  logic [RUNN_WIDTH-1:0]  run_n,
    input  logic [PC_WIDTH-1:0]    bp_addr,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic                   cpu_enable,
    output logic [COUNT_WIDTH-1:0] step_count,
    output logic                   halted,
    output logic [2:0]             state_dbg
);

    localparam int DIV_W = $clog2(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    run_state_t            state;
    run_state_t            state_next;
    logic                  fire;
    logic                  press;
    logic                  enable_d;
    logic [DIV_W-1:0]      divider;
    logic [RUNN_WIDTH-1:0] remaining;
    logic [PC_WIDTH-1:0]   bp_latched;
    logic [1:0]            run_mode;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock      (clock),
        .reset      (reset),
        .button_raw (button_raw),
        .press      (press)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state and the decision to issue an enable on the following cycle
    always_comb begin
        state_next = state;
        fire       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mode == MODE_FREE) begin
                    state_next = ST_RUN;
                end else if (press) begin
                    if (mode == MODE_STEP) begin
                        state_next = ST_STEP;
                        fire       = 1'b1;
                    end else if (mode == MODE_RUNN) begin
                        state_next = ST_RUNN;
                    end else begin
                        state_next = ST_BRK;
                    end
                end
            end
            ST_STEP: begin
                state_next = ST_IDLE;
            end
            ST_RUN: begin
                if (mode != MODE_FREE)       state_next = ST_IDLE;
                else if (divider == DIV_LAST) fire      = 1'b1;
            end
            ST_RUNN: begin
                if (mode != MODE_RUNN)        state_next = ST_IDLE;
                else if (remaining == '0)     state_next = ST_HALT;
                else if (divider == DIV_LAST) fire       = 1'b1;
            end
            ST_BRK: begin
                if (mode != MODE_BRK)                 state_next = ST_IDLE;
                else if (enable_d && pc == bp_latched) state_next = ST_HALT;
                else if (divider == DIV_LAST)         fire       = 1'b1;
            end
            ST_HALT: begin
                if (press || mode != run_mode) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Rate divider restarts on every entry into a run state
    always_ff @(posedge clock) begin
        if (reset) begin
            divider <= '0;
        end else if (is_divided(state) && state_next == state) begin
            divider <= (divider == DIV_LAST) ? '0 : divider + 1'b1;
        end else begin
            divider <= '0;
        end
    end

    // Capture run parameters when leaving IDLE and count down RUN_N steps
    always_ff @(posedge clock) begin
        if (reset) begin
            remaining  <= '0;
            bp_latched <= '0;
            run_mode   <= MODE_STEP;
        end else if (state == ST_IDLE && state_next != ST_IDLE) begin
            remaining  <= run_n;
            bp_latched <= bp_addr;
            run_mode   <= mode;
        end else if (state == ST_RUNN && fire) begin
            remaining <= remaining - 1'b1;
        end
    end

    // Registered enable strobe and its one-cycle-delayed copy for the PC compare
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_enable <= 1'b0;
            enable_d   <= 1'b0;
        end else begin
            cpu_enable <= fire;
            enable_d   <= cpu_enable;
        end
    end

    // Step counter for the HEX displays; clear wins over increment
    always_ff @(posedge clock) begin
        if (reset)           step_count <= '0;
        else if (count_clear) step_count <= '0;
        else if (cpu_enable)  step_count <= step_count + 1'b1;
    end

    assign halted    = (state == ST_HALT);
    assign state_dbg = state;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with a pulse-timing scoreboard:
// each expected cpu_enable pulse is queued as a gap (in clocks) from the
// previous pulse or phase start; gap 0 means "first pulse after a press".
module tb_cpu_run_controller;
    import cpu_dbg_pkg::*;

    localparam int RUN_DIV = 4;
    localparam int DEB     = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        button_raw;
    logic        count_clear;
    logic [7:0]  run_n;
    logic [31:0] bp_addr;
    logic [31:0] pc = 32'd0;
    logic        cpu_enable;
    logic [15:0] step_count;
    logic        halted;
    logic [2:0]  state_dbg;

    logic [1:0]  mode_w;
    logic        count_clear_w;
    logic        en_w;
    logic [3:0]  step_count_w;
    logic        halted_w;
    logic [2:0]  state_w;

    logic        pc_load;
    logic [31:0] pc_load_val;

    int cyc = 0;
    int ref_cyc = 0;
    int assert_count = 0;
    int fail_count = 0;
    int gap;
    int sb[$];
    logic prev_en = 1'b0;

    cpu_run_controller #(
        .RUN_DIV (RUN_DIV), .DEBOUNCE_CYCLES (DEB), .COUNT_WIDTH (16),
        .PC_WIDTH (32), .RUNN_WIDTH (8)
    ) dut (
        .clock (clock), .reset (reset), .mode (mode), .button_raw (button_raw),
        .count_clear (count_clear), .run_n (run_n), .bp_addr (bp_addr), .pc (pc),
        .cpu_enable (cpu_enable), .step_count (step_count), .halted (halted),
        .state_dbg (state_dbg)
    );

    // Narrow-counter instance used only to show wraparound quickly
    cpu_run_controller #(
        .RUN_DIV (RUN_DIV), .DEBOUNCE_CYCLES (DEB), .COUNT_WIDTH (4),
        .PC_WIDTH (32), .RUNN_WIDTH (8)
    ) dut_w (
        .clock (clock), .reset (reset), .mode (mode_w), .button_raw (button_raw),
        .count_clear (count_clear_w), .run_n (run_n), .bp_addr (bp_addr), .pc (pc),
        .cpu_enable (en_w), .step_count (step_count_w), .halted (halted_w),
        .state_dbg (state_w)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // CPU PC model: advances by one instruction on each enable
    always @(posedge clock) begin
        if (pc_load)         pc <= pc_load_val;
        else if (cpu_enable) pc <= pc + 32'd4;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic btn, input int n);
        mode       = m;
        button_raw = btn;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pressButton(input logic [1:0] m);
        ref_cyc = cyc;
        applyStimulus(m, 1'b1, 8);
        button_raw = 1'b0;
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput({tag, "_drain"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Scoreboard consumer: every observed pulse must match the next queued gap
    always @(negedge clock) begin
        if (cpu_enable === 1'b1) begin
            checkOutput("no_back_to_back", {31'd0, prev_en}, 32'd0);
            checkOutput("pulse_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
                gap = sb.pop_front();
                if (gap == 0)
                    checkOutput("first_pulse_window",
                                ((cyc - ref_cyc) >= 1 && (cyc - ref_cyc) <= 20) ? 32'd1 : 32'd0, 32'd1);
                else
                    checkOutput("pulse_gap", 32'(cyc - ref_cyc), 32'(gap));
            end
            ref_cyc = cyc;
        end
        prev_en = cpu_enable;
    end

    initial begin
        #60000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        reset = 1'b1; mode = MODE_STEP; button_raw = 1'b0; count_clear = 1'b0;
        run_n = 8'd0; bp_addr = 32'd0; pc_load = 1'b1; pc_load_val = 32'd0;
        mode_w = MODE_STEP; count_clear_w = 1'b0;
        @(posedge clock); #1;
        applyStimulus(MODE_STEP, 1'b0, 3);
        checkOutput("reset_enable", 32'(cpu_enable), 32'd0);
        checkOutput("reset_count", 32'(step_count), 32'd0);
        checkOutput("reset_halted", 32'(halted), 32'd0);
        checkOutput("reset_state", 32'(state_dbg), 32'd0);
        reset = 1'b0; pc_load = 1'b0;
        applyStimulus(MODE_STEP, 1'b0, 4);

        // STEP: two bounces then a long hold gives exactly one step
        applyStimulus(MODE_STEP, 1'b1, 1);
        applyStimulus(MODE_STEP, 1'b0, 1);
        applyStimulus(MODE_STEP, 1'b1, 1);
        applyStimulus(MODE_STEP, 1'b0, 1);
        sb.push_back(0);
        ref_cyc = cyc;
        applyStimulus(MODE_STEP, 1'b1, 20);
        applyStimulus(MODE_STEP, 1'b0, 12);
        checkOutput("step_drained", 32'(sb.size()), 32'd0);
        checkOutput("step_count", 32'(step_count), 32'd1);
        checkOutput("step_idle", 32'(state_dbg), 32'd0);

        // FREE: ten pulses, first 4 clocks after entry
        count_clear = 1'b1;
        applyStimulus(MODE_STEP, 1'b0, 1);
        count_clear = 1'b0;
        checkOutput("clear_count", 32'(step_count), 32'd0);
        ref_cyc = cyc;
        for (int i = 0; i < 10; i++) sb.push_back((i == 0) ? 5 : 4);
        applyStimulus(MODE_FREE, 1'b0, 0);
        waitDrain("free", 60);
        checkOutput("free_count", 32'(step_count), 32'd10);
        applyStimulus(MODE_STEP, 1'b0, 20);
        checkOutput("free_stop_count", 32'(step_count), 32'd10);
        checkOutput("free_stop_idle", 32'(state_dbg), 32'd0);

        // Mode change on the exact cycle a pulse is due suppresses it
        ref_cyc = cyc;
        applyStimulus(MODE_FREE, 1'b0, 4);
        applyStimulus(MODE_STEP, 1'b0, 10);
        checkOutput("suppressed_count", 32'(step_count), 32'd10);
        checkOutput("suppressed_idle", 32'(state_dbg), 32'd0);

        // RUN_N with three steps
        run_n = 8'd3;
        sb.push_back(0); sb.push_back(4); sb.push_back(4);
        applyStimulus(MODE_RUNN, 1'b0, 1);
        pressButton(MODE_RUNN);
        waitDrain("runn", 40);
        checkOutput("runn_halted", 32'(halted), 32'd1);
        checkOutput("runn_state", 32'(state_dbg), 32'd5);
        applyStimulus(MODE_RUNN, 1'b0, 10);
        checkOutput("runn_count", 32'(step_count), 32'd13);

        // A press leaves HALT without starting another run
        pressButton(MODE_RUNN);
        applyStimulus(MODE_RUNN, 1'b0, 10);
        checkOutput("halt_press_idle", 32'(state_dbg), 32'd0);
        checkOutput("halt_press_halted", 32'(halted), 32'd0);

        // RUN_N with zero steps halts immediately
        run_n = 8'd0;
        pressButton(MODE_RUNN);
        applyStimulus(MODE_RUNN, 1'b0, 8);
        checkOutput("runn0_halted", 32'(halted), 32'd1);
        checkOutput("runn0_count", 32'(step_count), 32'd13);
        applyStimulus(MODE_STEP, 1'b0, 2);
        checkOutput("halt_mode_idle", 32'(state_dbg), 32'd0);

        // BREAK at 0x0C with PC starting at 0
        bp_addr = 32'h0C; pc_load = 1'b1; pc_load_val = 32'd0;
        applyStimulus(MODE_BRK, 1'b0, 1);
        pc_load = 1'b0;
        sb.push_back(0); sb.push_back(4); sb.push_back(4);
        pressButton(MODE_BRK);
        waitDrain("brk", 40);
        checkOutput("brk_pc", pc, 32'h0C);
        checkOutput("brk_not_yet", 32'(halted), 32'd0);
        applyStimulus(MODE_BRK, 1'b0, 1);
        checkOutput("brk_halted", 32'(halted), 32'd1);
        applyStimulus(MODE_BRK, 1'b0, 10);
        checkOutput("brk_count", 32'(step_count), 32'd16);
        applyStimulus(MODE_STEP, 1'b0, 2);
        checkOutput("brk_exit_idle", 32'(state_dbg), 32'd0);

        // BREAK entered with PC already on the breakpoint runs past it
        pc_load = 1'b1; pc_load_val = 32'h0C;
        applyStimulus(MODE_STEP, 1'b0, 1);
        pc_load = 1'b0;
        sb.push_back(0); sb.push_back(4);
        pressButton(MODE_BRK);
        waitDrain("brk_at_bp", 40);
        checkOutput("brk_at_bp_running", 32'(halted), 32'd0);
        applyStimulus(MODE_STEP, 1'b0, 1);
        checkOutput("brk_at_bp_idle", 32'(state_dbg), 32'd0);
        applyStimulus(MODE_STEP, 1'b0, 8);
        checkOutput("brk_at_bp_count", 32'(step_count), 32'd18);

        // Reset in the middle of RUN_N with two steps left
        run_n = 8'd3;
        sb.push_back(0);
        pressButton(MODE_RUNN);
        waitDrain("runn_reset", 40);
        reset = 1'b1;
        applyStimulus(MODE_RUNN, 1'b0, 1);
        checkOutput("midreset_enable", 32'(cpu_enable), 32'd0);
        checkOutput("midreset_count", 32'(step_count), 32'd0);
        checkOutput("midreset_state", 32'(state_dbg), 32'd0);
        reset = 1'b0;
        applyStimulus(MODE_RUNN, 1'b0, 12);
        checkOutput("postreset_state", 32'(state_dbg), 32'd0);
        applyStimulus(MODE_STEP, 1'b0, 2);

        // Clear coincident with a pulse leaves the counter at zero
        ref_cyc = cyc;
        sb.push_back(5); sb.push_back(4);
        applyStimulus(MODE_FREE, 1'b0, 9);
        count_clear = 1'b1;
        applyStimulus(MODE_FREE, 1'b0, 1);
        count_clear = 1'b0;
        checkOutput("clear_beats_inc", 32'(step_count), 32'd0);
        applyStimulus(MODE_STEP, 1'b0, 6);
        checkOutput("clear_drained", 32'(sb.size()), 32'd0);

        // Counter wraparound on the 4-bit instance
        count_clear_w = 1'b1; mode_w = MODE_FREE;
        applyStimulus(MODE_STEP, 1'b0, 1);
        count_clear_w = 1'b0;
        applyStimulus(MODE_STEP, 1'b0, 62);
        checkOutput("wrap_before", 32'(step_count_w), 32'hF);
        applyStimulus(MODE_STEP, 1'b0, 3);
        checkOutput("wrap_after", 32'(step_count_w), 32'h0);
        mode_w = MODE_STEP;
        applyStimulus(MODE_STEP, 1'b0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
